// File: rtl/sound_latch_if.sv
// Bus bundle between the 68k/Z80 side logic and the sound latch controller.
// master drives the CPU strobes and data; slave is the latch controller itself.
interface sound_latch_if;
    logic       m68k_latch_cs;
    logic       z80_latch_read_cs;
    logic [7:0] m68k_din;
    logic       z80_latch_cs;
    logic       z80_rd_n;
    logic       z80_wr_n;
    logic [7:0] z80_dout;
    logic [7:0] sound_latch;
    logic [7:0] reply_latch;
    logic       z80_nmi_n;
    logic       cmd_pending;
    logic       reply_pending;
    logic       overrun;

    modport master (
        output m68k_latch_cs, z80_latch_read_cs, m68k_din,
        output z80_latch_cs, z80_rd_n, z80_wr_n, z80_dout,
        input  sound_latch, reply_latch, z80_nmi_n,
        input  cmd_pending, reply_pending, overrun
    );

    modport slave (
        input  m68k_latch_cs, z80_latch_read_cs, m68k_din,
        input  z80_latch_cs, z80_rd_n, z80_wr_n, z80_dout,
        output sound_latch, reply_latch, z80_nmi_n,
        output cmd_pending, reply_pending, overrun
    );
endinterface

// File: rtl/sound_latch_ctrl.sv
// 68k -> Z80 command latch and Z80 -> 68k reply latch, with a rate-limited
// Z80 NMI pulse generator kicked by every 68k command write.
module sound_latch_ctrl #(
    parameter int unsigned NMI_WIDTH = 16,
    parameter int unsigned NMI_GAP   = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    sound_latch_if.slave  bus
);

    localparam logic [7:0] WIDTH_LOAD = 8'(NMI_WIDTH - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(NMI_GAP - 1);

    // Strobe bit order: 0 = W68, 1 = R68, 2 = RZ, 3 = WZ
    localparam int EV_W68 = 0;
    localparam int EV_R68 = 1;
    localparam int EV_RZ  = 2;
    localparam int EV_WZ  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } nmi_state_t;

    logic [3:0] strobe;
    logic [3:0] strobe_prev_q, strobe_prev_d;
    logic [3:0] strobe_rise;

    logic [7:0] sound_latch_q, sound_latch_d;
    logic [7:0] reply_latch_q, reply_latch_d;
    logic       cmd_pending_q, cmd_pending_d;
    logic       reply_pending_q, reply_pending_d;
    logic       overrun_q, overrun_d;

    nmi_state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       nmi_req_q, nmi_req_d;
    logic       nmi_n_q, nmi_n_d;

    logic w68, r68, rz, wz;

    assign strobe[EV_W68] = bus.m68k_latch_cs;
    assign strobe[EV_R68] = bus.z80_latch_read_cs;
    assign strobe[EV_RZ]  = bus.z80_latch_cs & ~bus.z80_rd_n;
    assign strobe[EV_WZ]  = bus.z80_latch_cs & ~bus.z80_wr_n;

    // History is cleared in reset so a strobe held through release fires once.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_edge
            assign strobe_rise[gi]   = strobe[gi] & ~strobe_prev_q[gi];
            assign strobe_prev_d[gi] = strobe[gi];
        end
    endgenerate

    assign w68 = strobe_rise[EV_W68];
    assign r68 = strobe_rise[EV_R68];
    assign rz  = strobe_rise[EV_RZ];
    assign wz  = strobe_rise[EV_WZ];

    always_comb begin
        sound_latch_d   = sound_latch_q;
        cmd_pending_d   = cmd_pending_q;
        overrun_d       = overrun_q;
        reply_latch_d   = reply_latch_q;
        reply_pending_d = reply_pending_q;

        // A coincident Z80 read consumes the old byte, so the write wins.
        if (w68) begin
            sound_latch_d = bus.m68k_din;
            cmd_pending_d = 1'b1;
            if (cmd_pending_q && !rz) begin
                overrun_d = 1'b1;
            end
        end else if (rz) begin
            cmd_pending_d = 1'b0;
        end

        if (wz) begin
            reply_latch_d   = bus.z80_dout;
            reply_pending_d = 1'b1;
        end else if (r68) begin
            reply_pending_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nmi_req_d = nmi_req_q;

        if (w68 && state_q == GAP) begin
            nmi_req_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (nmi_req_q || w68) begin
                    state_d = PULSE;
                    cnt_d   = WIDTH_LOAD;
                end
            end
            PULSE: begin
                if (cnt_q == 8'd0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                // A request landing on the final gap cycle is picked up from IDLE.
                if (cnt_q == 8'd0) begin
                    if (nmi_req_q) begin
                        state_d = PULSE;
                        cnt_d   = WIDTH_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        if (state_d == PULSE && state_q != PULSE) begin
            nmi_req_d = 1'b0;
        end

        nmi_n_d = (state_d != PULSE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            strobe_prev_q   <= 4'b0000;
            sound_latch_q   <= 8'h00;
            reply_latch_q   <= 8'h00;
            cmd_pending_q   <= 1'b0;
            reply_pending_q <= 1'b0;
            overrun_q       <= 1'b0;
            state_q         <= IDLE;
            cnt_q           <= 8'd0;
            nmi_req_q       <= 1'b0;
            nmi_n_q         <= 1'b1;
        end else begin
            strobe_prev_q   <= strobe_prev_d;
            sound_latch_q   <= sound_latch_d;
            reply_latch_q   <= reply_latch_d;
            cmd_pending_q   <= cmd_pending_d;
            reply_pending_q <= reply_pending_d;
            overrun_q       <= overrun_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            nmi_req_q       <= nmi_req_d;
            nmi_n_q         <= nmi_n_d;
        end
    end

    assign bus.sound_latch   = sound_latch_q;
    assign bus.reply_latch   = reply_latch_q;
    assign bus.cmd_pending   = cmd_pending_q;
    assign bus.reply_pending = reply_pending_q;
    assign bus.overrun       = overrun_q;
    assign bus.z80_nmi_n     = nmi_n_q;

endmodule

// File: tb/tb_sound_latch_ctrl.sv
// Directed bench for sound_latch_ctrl: expectations are queued as stimulus is
// driven and popped against DUT outputs; an NMI monitor records pulse/gap lengths.
module tb_sound_latch_ctrl;

    logic clk;
    logic reset_n;

    sound_latch_if bus();

    sound_latch_ctrl #(
        .NMI_WIDTH(16),
        .NMI_GAP  (8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    int   pulse_q[$];
    int   gap_q[$];
    int   low_cnt  = 0;
    int   high_cnt = 0;
    logic nmi_prev = 1'b1;

    always @(negedge clk) begin
        if (bus.z80_nmi_n === 1'b0) begin
            if (nmi_prev !== 1'b0) begin
                gap_q.push_back(high_cnt);
                low_cnt = 1;
            end else begin
                low_cnt++;
            end
        end else begin
            if (nmi_prev === 1'b0) begin
                pulse_q.push_back(low_cnt);
                high_cnt = 1;
            end else begin
                high_cnt++;
            end
        end
        nmi_prev = bus.z80_nmi_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: got %0h required a queued expectation", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val)
            else begin
                miscompares++;
                $error("FAIL %s: got %0h required %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    task automatic clear_mon();
        pulse_q.delete();
        gap_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        clear_mon();
        $display("txn reset");
    endtask

    task automatic w68(input logic [7:0] d, input int hold);
        bus.m68k_din      = d;
        bus.m68k_latch_cs = 1'b1;
        cyc(hold);
        bus.m68k_latch_cs = 1'b0;
        $display("txn w68 din=%02h hold=%0d", d, hold);
    endtask

    task automatic rz_pulse();
        bus.z80_latch_cs = 1'b1;
        bus.z80_rd_n     = 1'b0;
        step();
        bus.z80_latch_cs = 1'b0;
        bus.z80_rd_n     = 1'b1;
        $display("txn rz");
    endtask

    task automatic wz(input logic [7:0] d, input int hold);
        bus.z80_dout     = d;
        bus.z80_latch_cs = 1'b1;
        bus.z80_wr_n     = 1'b0;
        step();
        bus.z80_dout = ~d;
        cyc(hold - 1);
        bus.z80_latch_cs = 1'b0;
        bus.z80_wr_n     = 1'b1;
        $display("txn wz dout=%02h hold=%0d", d, hold);
    endtask

    task automatic r68_pulse();
        bus.z80_latch_read_cs = 1'b1;
        step();
        bus.z80_latch_read_cs = 1'b0;
        $display("txn r68");
    endtask

    initial begin
        reset_n               = 1'b0;
        bus.m68k_latch_cs     = 1'b0;
        bus.z80_latch_read_cs = 1'b0;
        bus.m68k_din          = 8'h00;
        bus.z80_latch_cs      = 1'b0;
        bus.z80_rd_n          = 1'b1;
        bus.z80_wr_n          = 1'b1;
        bus.z80_dout          = 8'h00;

        // Reset values
        push_exp("rst_sound_latch", 32'h00);
        push_exp("rst_reply_latch", 32'h00);
        push_exp("rst_cmd_pending", 32'h0);
        push_exp("rst_reply_pending", 32'h0);
        push_exp("rst_overrun", 32'h0);
        push_exp("rst_nmi_n", 32'h1);
        do_reset();
        pop_check(32'(bus.sound_latch));
        pop_check(32'(bus.reply_latch));
        pop_check(32'(bus.cmd_pending));
        pop_check(32'(bus.reply_pending));
        pop_check(32'(bus.overrun));
        pop_check(32'(bus.z80_nmi_n));

        // Single command, strobe held 4 cycles: one 16-cycle pulse, 1-cycle latency
        push_exp("t1_nmi_first_cycle", 32'h0);
        push_exp("t1_sound_latch", 32'h5A);
        push_exp("t1_cmd_pending", 32'h1);
        push_exp("t1_pulse_count", 32'd1);
        push_exp("t1_pulse_len", 32'd16);
        bus.m68k_din      = 8'h5A;
        bus.m68k_latch_cs = 1'b1;
        step();
        pop_check(32'(bus.z80_nmi_n));
        cyc(3);
        bus.m68k_latch_cs = 1'b0;
        $display("txn w68 din=5a hold=4");
        cyc(40);
        pop_check(32'(bus.sound_latch));
        pop_check(32'(bus.cmd_pending));
        pop_check(32'(pulse_q.size()));
        pop_check(pulse_q.size() > 0 ? 32'(pulse_q[0]) : 32'hFFFF_FFFF);

        // Command, Z80 read, second command during GAP: no overrun, gap of 8
        do_reset();
        push_exp("t2_overrun", 32'h0);
        push_exp("t2_sound_latch", 32'h22);
        push_exp("t2_pulse_count", 32'd2);
        push_exp("t2_pulse2_len", 32'd16);
        push_exp("t2_gap_len", 32'd8);
        w68(8'h11, 1);
        cyc(3);
        rz_pulse();
        cyc(15);
        w68(8'h22, 1);
        cyc(40);
        pop_check(32'(bus.overrun));
        pop_check(32'(bus.sound_latch));
        pop_check(32'(pulse_q.size()));
        pop_check(pulse_q.size() > 1 ? 32'(pulse_q[1]) : 32'hFFFF_FFFF);
        pop_check(gap_q.size() > 1 ? 32'(gap_q[1]) : 32'hFFFF_FFFF);

        // Second command during GAP without a read: overrun, back-to-back after GAP
        do_reset();
        push_exp("t3_overrun", 32'h1);
        push_exp("t3_sound_latch", 32'h22);
        push_exp("t3_cmd_pending", 32'h1);
        push_exp("t3_pulse_count", 32'd2);
        push_exp("t3_gap_len", 32'd8);
        w68(8'h11, 1);
        cyc(19);
        w68(8'h22, 1);
        cyc(40);
        pop_check(32'(bus.overrun));
        pop_check(32'(bus.sound_latch));
        pop_check(32'(bus.cmd_pending));
        pop_check(32'(pulse_q.size()));
        pop_check(gap_q.size() > 1 ? 32'(gap_q[1]) : 32'hFFFF_FFFF);

        // Write coincident with Z80 read while in PULSE
        do_reset();
        push_exp("t4_z80_sees_old", 32'h11);
        push_exp("t4_sound_latch", 32'h33);
        push_exp("t4_cmd_pending", 32'h1);
        push_exp("t4_overrun", 32'h0);
        push_exp("t4_single_pulse", 32'd1);
        w68(8'h11, 1);
        cyc(3);
        bus.m68k_din      = 8'h33;
        bus.m68k_latch_cs = 1'b1;
        bus.z80_latch_cs  = 1'b1;
        bus.z80_rd_n      = 1'b0;
        pop_check(32'(bus.sound_latch));
        step();
        bus.m68k_latch_cs = 1'b0;
        bus.z80_latch_cs  = 1'b0;
        bus.z80_rd_n      = 1'b1;
        $display("txn w68+rz din=33");
        pop_check(32'(bus.sound_latch));
        pop_check(32'(bus.cmd_pending));
        pop_check(32'(bus.overrun));
        cyc(40);
        pop_check(32'(pulse_q.size()));

        // Reply path: held WZ captures first byte only, R68 clears, coincident keeps 1
        do_reset();
        push_exp("t5_reply_latch", 32'hA5);
        push_exp("t5_reply_pending_set", 32'h1);
        push_exp("t5_reply_pending_clr", 32'h0);
        push_exp("t5_coinc_reply_latch", 32'h3C);
        push_exp("t5_coinc_reply_pending", 32'h1);
        push_exp("t5_no_nmi", 32'd0);
        wz(8'hA5, 3);
        pop_check(32'(bus.reply_latch));
        pop_check(32'(bus.reply_pending));
        cyc(2);
        r68_pulse();
        pop_check(32'(bus.reply_pending));
        cyc(2);
        bus.z80_dout          = 8'h3C;
        bus.z80_latch_cs      = 1'b1;
        bus.z80_wr_n          = 1'b0;
        bus.z80_latch_read_cs = 1'b1;
        step();
        bus.z80_latch_cs      = 1'b0;
        bus.z80_wr_n          = 1'b1;
        bus.z80_latch_read_cs = 1'b0;
        $display("txn wz+r68 dout=3c");
        pop_check(32'(bus.reply_latch));
        pop_check(32'(bus.reply_pending));
        cyc(5);
        pop_check(32'(pulse_q.size() + gap_q.size()));

        // Reset during cycle 5 of PULSE
        do_reset();
        push_exp("t6_nmi_after_rst", 32'h1);
        push_exp("t6_sound_latch", 32'h00);
        push_exp("t6_cmd_pending", 32'h0);
        push_exp("t6_overrun", 32'h0);
        push_exp("t6_no_pulse_after", 32'd0);
        w68(8'h44, 1);
        bus.m68k_din = 8'h55;
        cyc(4);
        reset_n = 1'b0;
        step();
        $display("txn reset mid-pulse");
        pop_check(32'(bus.z80_nmi_n));
        pop_check(32'(bus.sound_latch));
        pop_check(32'(bus.cmd_pending));
        pop_check(32'(bus.overrun));
        reset_n = 1'b1;
        step();
        clear_mon();
        cyc(40);
        pop_check(32'(pulse_q.size()));

        // Strobe held across reset release fires once on first cycle after release
        push_exp("t7_sound_latch", 32'h77);
        push_exp("t7_cmd_pending", 32'h1);
        push_exp("t7_nmi_n", 32'h0);
        push_exp("t7_single_pulse", 32'd1);
        reset_n           = 1'b0;
        bus.m68k_din      = 8'h77;
        bus.m68k_latch_cs = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        clear_mon();
        step();
        $display("txn w68 held across reset release din=77");
        pop_check(32'(bus.sound_latch));
        pop_check(32'(bus.cmd_pending));
        pop_check(32'(bus.z80_nmi_n));
        cyc(5);
        bus.m68k_latch_cs = 1'b0;
        cyc(40);
        pop_check(32'(pulse_q.size()));

        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            miscompares++;
            $display("FAIL %s: got no observation required %0h", e.tag, e.val);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sound_latch_ctrl.md
SOUND_LATCH_CTRL -- requirements
Module: sound_latch_ctrl

Interface
REQ-001 Parameter NMI_WIDTH, default 16, meaning Z80 NMI low-pulse length in clk cycles (range 1..255).
REQ-002 Parameter NMI_GAP, default 8, meaning minimum clk cycles NMI stays high between pulses (range 1..255).
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 m68k_latch_cs  in  1  68k write strobe to sound latch (already qualified by !rw and !as_n).
REQ-006 z80_latch_read_cs  in  1  68k read strobe of reply latch.
REQ-007 m68k_din  in  8  68k data bus low byte.
REQ-008 z80_latch_cs  in  1  Z80 memory select of latch address 0xF800.
REQ-009 z80_rd_n, z80_wr_n  in  1 each  Z80 read and write strobes, active low.
REQ-010 z80_dout  in  8  Z80 data out.
REQ-011 sound_latch  out  8  command byte presented to Z80 data-in mux.
REQ-012 reply_latch  out  8  reply byte presented to 68k data-in mux.
REQ-013 z80_nmi_n  out  1  Z80 NMI, active low.
REQ-014 cmd_pending  out  1  command written by 68k, not yet read by Z80.
REQ-015 reply_pending  out  1  reply written by Z80, not yet read by 68k.
REQ-016 overrun  out  1  sticky: 68k overwrote an unread command.

Function
REQ-017 Events SHALL be rising-edge detected on the strobe terms: W68 = m68k_latch_cs; R68 = z80_latch_read_cs; RZ = z80_latch_cs & !z80_rd_n; WZ = z80_latch_cs & !z80_wr_n; one event per strobe assertion regardless of how long it is held.
REQ-018 On W68: sound_latch <= m68k_din next cycle; cmd_pending <= 1; overrun <= 1 if cmd_pending was already 1 and RZ is not in the same cycle.
REQ-019 On RZ: cmd_pending <= 0 next cycle; sound_latch holds its value.
REQ-020 W68 and RZ in the same cycle: Z80 reads the pre-update sound_latch; the new byte is stored; cmd_pending ends at 1; overrun is not set.
REQ-021 On WZ: reply_latch <= z80_dout next cycle; reply_pending <= 1.
REQ-022 On R68: reply_pending <= 0; WZ and R68 in the same cycle: reply_pending ends at 1, reply_latch takes the new byte.
REQ-023 NMI FSM states: IDLE, PULSE, GAP; a request flag nmi_req is set by W68 and cleared on entry to PULSE.
REQ-024 IDLE: z80_nmi_n=1; on nmi_req or W68 go to PULSE, loading the counter with NMI_WIDTH-1.
REQ-025 PULSE: z80_nmi_n=0; count down; at 0 go to GAP, loading the counter with NMI_GAP-1; W68 during PULSE updates the latch but sets no new request.
REQ-026 GAP: z80_nmi_n=1; count down; at 0 go to PULSE if nmi_req, else IDLE; W68 during GAP sets nmi_req.
REQ-027 Latency: first cycle of z80_nmi_n=0 SHALL be the cycle after the W68 edge when in IDLE; pulse is exactly NMI_WIDTH cycles low.
REQ-028 Counters SHALL be 8 bits and SHALL never wrap; loads occur only on state entry.
REQ-029 overrun SHALL clear only on reset.

Reset
REQ-030 While reset_n=0 at a clk edge: sound_latch=0x00, reply_latch=0x00, cmd_pending=0, reply_pending=0, overrun=0, z80_nmi_n=1, FSM=IDLE, nmi_req=0, and all edge-detect history is set to 0.
REQ-031 Reset asserted mid-PULSE SHALL drive z80_nmi_n=1 on the next cycle, with no residual request after release.
REQ-032 A strobe held high across reset release SHALL register as an event on the first cycle after release.

Verification
REQ-033 Reset, then W68 with din=0x5A held 4 cycles -> sound_latch=0x5A, cmd_pending=1, z80_nmi_n low for exactly 16 cycles starting 1 cycle after the edge, single pulse.
REQ-034 W68 0x11, then RZ, then W68 0x22 -> overrun stays 0, two NMI pulses separated by at least 8 high cycles.
REQ-035 W68 0x11, then W68 0x22 during GAP with no RZ -> overrun=1, sound_latch=0x22, second pulse starts right after GAP ends.
REQ-036 W68 0x33 in the same cycle as RZ with latch=0x11 -> Z80 sees 0x11, cmd_pending=1, overrun=0.
REQ-037 WZ z80_dout=0xA5, then R68 -> reply_latch=0xA5, reply_pending goes 1 then 0; WZ and R68 coincident -> reply_pending=1.
REQ-038 reset_n=0 at cycle 5 of PULSE -> z80_nmi_n=1 the next cycle, all outputs at reset values, no pulse after release.
